// File: rtl/clause_cell_n_pkg.sv
// Shared encodings and types for the SAT clause cell.
//   Literal slot encoding {pos,neg}: LIT_EMPTY / LIT_POS / LIT_NEG (11 behaves as empty).
//   Variable value encoding val[1:0]: VAL_U (unassigned) / VAL_T / VAL_F.
//   lit_class_t: per-slot classification result.
//   imp_state_t: implication request FSM states.
package clause_cell_n_pkg;
  localparam logic [1:0] LIT_EMPTY = 2'b00;
  localparam logic [1:0] LIT_POS   = 2'b10;
  localparam logic [1:0] LIT_NEG   = 2'b01;
  localparam logic [1:0] VAL_U     = 2'b00;
  localparam logic [1:0] VAL_T     = 2'b10;
  localparam logic [1:0] VAL_F     = 2'b01;

  // CL_EMPTY must stay the all-zero code: a flushed pipeline reads as an empty clause.
  typedef enum logic [1:0] {
    CL_EMPTY = 2'd0,
    CL_FREE  = 2'd1,
    CL_FALSE = 2'd2,
    CL_TRUE  = 2'd3
  } lit_class_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } imp_state_t;
endpackage

// File: rtl/clause_cell_n_if.sv
// Implication request channel between a clause cell and the implication arbiter.
//   imp_valid_o  request valid (cell -> arbiter)
//   imp_ready_i  arbiter accepts (arbiter -> cell)
//   imp_idx_o    slot index of the forced literal
//   imp_val_o    value to assign to that variable (10 true / 01 false)
// master = clause cell, slave = arbiter.
interface clause_cell_n_if #(
  parameter int NUM_LITS = 8
);
  localparam int IDX_W = $clog2(NUM_LITS);

  logic             imp_valid_o;
  logic             imp_ready_i;
  logic [IDX_W-1:0] imp_idx_o;
  logic [1:0]       imp_val_o;

  modport master (output imp_valid_o, imp_idx_o, imp_val_o, input imp_ready_i);
  modport slave  (input imp_valid_o, imp_idx_o, imp_val_o, output imp_ready_i);
endinterface

// File: rtl/clause_cell_n_lit_classify.sv
// Per-slot combinational literal classifier.
//   lit  in  stored literal {pos,neg}
//   val  in  variable value val[1:0] (implied bit is not needed here)
//   cls  out CL_EMPTY / CL_FREE / CL_FALSE / CL_TRUE
module clause_cell_n_lit_classify
  import clause_cell_n_pkg::*;
(
  input  logic [1:0] lit,
  input  logic [1:0] val,
  output lit_class_t cls
);
  logic empty;
  logic is_true;

  always_comb begin
    // 11 is an illegal literal code and is deliberately folded into "empty".
    empty   = (lit == LIT_EMPTY) || (lit == 2'b11);
    is_true = ((lit == LIT_POS) && (val == VAL_T)) ||
              ((lit == LIT_NEG) && (val == VAL_F));
    if (empty)             cls = CL_EMPTY;
    else if (is_true)      cls = CL_TRUE;
    else if (val != VAL_U) cls = CL_FALSE;
    else                   cls = CL_FREE;
  end
endmodule

// File: rtl/clause_cell_n.sv
// Clause cell: stores NUM_LITS literals of one clause, classifies them against the
// variable-value bus in a 2-stage pipeline and raises an implication request when
// the clause becomes unit.
//   clk, rst        clock, asynchronous active-high reset
//   var_value_i/o   per-slot {implied, val[1:0]} chain; slot imp_idx_o overridden while requesting
//   wr_i, lit_i     load literal storage (flushes pipeline, aborts any request)
//   lit_o           stored literals
//   freelitcnt_o    registered free count (0, 1, 2 = two or more)
//   clausesat_o     registered "some literal is true"
//   imp_drv_i       implication enable
//   imp             implication request channel (master)
//   cclause_drv_i   conflict reporting enable; cclause_o = registered conflict & enable
//   act_o           conflict-activity counter
// Optional feature macro: CLAUSE_ACT_EN builds the saturating conflict-activity
// counter; without it act_o is tied to 0.
module clause_cell_n
  import clause_cell_n_pkg::*;
#(
  parameter int NUM_LITS = 8,
  parameter int ACT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_LITS*3-1:0] var_value_i,
  output logic [NUM_LITS*3-1:0] var_value_o,
  input  logic                  wr_i,
  input  logic [NUM_LITS*2-1:0] lit_i,
  output logic [NUM_LITS*2-1:0] lit_o,
  output logic [1:0]            freelitcnt_o,
  output logic                  clausesat_o,
  input  logic                  imp_drv_i,
  clause_cell_n_if.master       imp,
  input  logic                  cclause_drv_i,
  output logic                  cclause_o,
  output logic [ACT_W-1:0]      act_o
);
  localparam int IDX_W = $clog2(NUM_LITS);

  logic [NUM_LITS*2-1:0] lit_q;
  lit_class_t            cls_d [NUM_LITS];
  lit_class_t            cls_q [NUM_LITS];

  // stage-2 status
  logic             sat_q, conf_q;
  logic [1:0]       free_q;
  logic [IDX_W-1:0] ffree_q;

  // reduction of stage-1 classes
  logic             any_true, any_lit, found;
  logic [1:0]       n_free;
  logic [IDX_W-1:0] first_free;

  imp_state_t       state_q, state_d;
  logic             latch;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       val_q;
  logic [1:0]       lit_sel;
  logic             unit;

  // literal storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       lit_q <= '0;
    else if (wr_i) lit_q <= lit_i;
  end
  assign lit_o = lit_q;

  for (genvar g = 0; g < NUM_LITS; g++) begin : g_slot
    clause_cell_n_lit_classify u_cls (
      .lit (lit_q[2*g +: 2]),
      .val (var_value_i[3*g +: 2]),
      .cls (cls_d[g])
    );
  end

  // stage 1: per-slot class
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LITS; i++) cls_q[i] <= CL_EMPTY;
    end else if (wr_i) begin
      for (int i = 0; i < NUM_LITS; i++) cls_q[i] <= CL_EMPTY;
    end else begin
      for (int i = 0; i < NUM_LITS; i++) cls_q[i] <= cls_d[i];
    end
  end

  // status reduction + lowest-index free slot priority encoder
  always_comb begin
    any_true   = 1'b0;
    any_lit    = 1'b0;
    found      = 1'b0;
    n_free     = 2'd0;
    first_free = '0;
    for (int i = 0; i < NUM_LITS; i++) begin
      if (cls_q[i] != CL_EMPTY) any_lit = 1'b1;
      if (cls_q[i] == CL_TRUE)  any_true = 1'b1;
      if (cls_q[i] == CL_FREE) begin
        if (!found) first_free = IDX_W'(i);
        found = 1'b1;
        if (n_free != 2'd2) n_free = n_free + 2'd1;
      end
    end
  end

  // stage 2: clause status
  always_ff @(posedge clk or posedge rst) begin
    if (rst || wr_i) begin
      sat_q   <= 1'b0;
      conf_q  <= 1'b0;
      free_q  <= 2'd0;
      ffree_q <= '0;
    end else begin
      sat_q   <= any_true;
      conf_q  <= any_lit && !any_true && (n_free == 2'd0);
      free_q  <= n_free;
      ffree_q <= first_free;
    end
  end

  assign freelitcnt_o = free_q;
  assign clausesat_o  = sat_q;
  assign cclause_o    = conf_q & cclause_drv_i;
  assign unit         = (free_q == 2'd1) && !sat_q;

  // literal at the lowest free slot decides the forced value
  always_comb begin
    lit_sel = LIT_EMPTY;
    for (int i = 0; i < NUM_LITS; i++)
      if (ffree_q == IDX_W'(i)) lit_sel = lit_q[2*i +: 2];
  end

  // implication FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: if (unit && imp_drv_i) begin
        state_d = REQ;
        latch   = 1'b1;
      end
      // a handshake beats a simultaneous loss of unit status
      REQ:  if (imp.imp_ready_i)          state_d = WAIT;
            else if (!unit || !imp_drv_i) state_d = IDLE;
      // stay here until status changes so the same implication is not reissued
      WAIT: if (!unit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wr_i) begin
      state_d = IDLE;
      latch   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      val_q <= 2'b00;
    end else if (latch) begin
      idx_q <= ffree_q;
      val_q <= (lit_sel == LIT_POS) ? VAL_T : VAL_F;
    end
  end

  assign imp.imp_valid_o = (state_q == REQ);
  assign imp.imp_idx_o   = idx_q;
  assign imp.imp_val_o   = val_q;

  // downstream cells see the pending implication as an implied assignment
  always_comb begin
    var_value_o = var_value_i;
    for (int i = 0; i < NUM_LITS; i++)
      if ((state_q == REQ) && (idx_q == IDX_W'(i)))
        var_value_o[3*i +: 3] = {1'b1, val_q};
  end

`ifdef CLAUSE_ACT_EN
  logic             conf_prev;
  logic [ACT_W-1:0] act_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conf_prev <= 1'b0;
      act_q     <= '0;
    end else begin
      conf_prev <= conf_q;
      if (wr_i)
        act_q <= '0;
      else if (conf_q && !conf_prev && cclause_drv_i && (act_q != {ACT_W{1'b1}}))
        act_q <= act_q + 1'b1;
    end
  end
  assign act_o = act_q;
`else
  assign act_o = '0;
`endif
endmodule
